// File: rtl/tcon_pkg.sv
// Shared types and constants for the two-requester mux arbiter.
package tcon_pkg;

    localparam int TCON_W         = 8;
    localparam int TCON_MAX_BURST = 4;

    // Side encoding; must match the datapath select polarity (1 = A side).
    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } tcon_state_e;

endpackage

// File: rtl/tcon_out_reg.sv
// Single-stage valid/ready output register; load says it can take a beat now.
module tcon_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         out_ready,
    output logic         load,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q,  out_data_d;

    assign load      = ~out_valid_q | out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Capture an accepted beat when the stage is free, otherwise hold it.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (load) begin
            out_valid_d = in_valid;
            if (in_valid) begin
                out_data_d = in_data;
            end
        end
    end

    // Output stage flops, cleared on reset so a held beat is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: rtl/tcon_mux_arbiter.sv
// Round-robin, burst-limited arbiter between requesters A and B driving the
// datapath select line and a registered valid/ready output stage.
module tcon_mux_arbiter
    import tcon_pkg::*;
#(
    parameter int W         = TCON_W,
    parameter int MAX_BURST = TCON_MAX_BURST,
    parameter int CNT_W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         a_valid,
    input  logic [W-1:0] a_data,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [W-1:0] b_data,
    output logic         b_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         sel,
    output logic         busy
);

    tcon_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             sel_q,   sel_d;
    logic             last_q,  last_d;

    logic             load;
    logic             a_ready_c, b_ready_c;
    logic             acc_a, acc_b, acc_any;
    logic [W-1:0]     acc_data;
    logic             cnt_max;

    assign cnt_max  = (cnt_q == CNT_W'(MAX_BURST));
    assign acc_a    = a_valid & a_ready_c;
    assign acc_b    = b_valid & b_ready_c;
    assign acc_any  = acc_a | acc_b;
    assign acc_data = acc_a ? a_data : b_data;

    assign a_ready  = a_ready_c;
    assign b_ready  = b_ready_c;
    assign sel      = sel_q;
    assign busy     = (state_q != IDLE);

    // Next-state, burst counter and ready generation for the arbiter FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        last_d    = last_q;
        a_ready_c = 1'b0;
        b_ready_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (a_valid && (!b_valid || last_q == SEL_B)) begin
                    state_d = GNT_A;
                    cnt_d   = '0;
                    sel_d   = SEL_A;
                    last_d  = SEL_A;
                end else if (b_valid) begin
                    state_d = GNT_B;
                    cnt_d   = '0;
                    sel_d   = SEL_B;
                    last_d  = SEL_B;
                end
            end
            GNT_A: begin
                a_ready_c = load & ~(cnt_max & b_valid);
                if (!a_valid) begin
                    if (b_valid) begin
                        state_d = GNT_B;
                        cnt_d   = '0;
                        sel_d   = SEL_B;
                        last_d  = SEL_B;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_max && b_valid) begin
                    state_d = GNT_B;
                    cnt_d   = '0;
                    sel_d   = SEL_B;
                    last_d  = SEL_B;
                end else if (a_ready_c && !cnt_max) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GNT_B: begin
                b_ready_c = load & ~(cnt_max & a_valid);
                if (!b_valid) begin
                    if (a_valid) begin
                        state_d = GNT_A;
                        cnt_d   = '0;
                        sel_d   = SEL_A;
                        last_d  = SEL_A;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_max && a_valid) begin
                    state_d = GNT_A;
                    cnt_d   = '0;
                    sel_d   = SEL_A;
                    last_d  = SEL_A;
                end else if (b_ready_c && !cnt_max) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state register; last winner resets to B so A goes first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= SEL_B;
            last_q  <= SEL_B;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    tcon_out_reg #(
        .W(W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (acc_any),
        .in_data   (acc_data),
        .out_ready (out_ready),
        .load      (load),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_tcon_mux_arbiter.sv
// Directed self-checking bench for tcon_mux_arbiter.
module tb_tcon_mux_arbiter;

    logic       clk;
    logic       rst_n;
    logic       a_valid;
    logic [7:0] a_data;
    logic       a_ready;
    logic       b_valid;
    logic [7:0] b_data;
    logic       b_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       sel;
    logic       busy;

    int checks = 0;
    int errors = 0;

    tcon_mux_arbiter #(
        .W(8),
        .MAX_BURST(4),
        .CNT_W(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic av, input logic [7:0] ad,
                                 input logic bv, input logic [7:0] bd,
                                 input logic ordy);
        a_valid   = av;
        a_data    = ad;
        b_valid   = bv;
        b_data    = bd;
        out_ready = ordy;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs,
                               input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check the ready exclusivity, then advance to 1 time unit past the edge.
    task automatic cycle();
        checkOutput("ready_mutex", {7'b0, a_ready & b_ready}, 8'h00);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        #12;
        checkOutput("rst_out_valid", {7'b0, out_valid}, 8'h00);
        checkOutput("rst_out_data",  out_data,          8'h00);
        checkOutput("rst_sel",       {7'b0, sel},       8'h00);
        checkOutput("rst_busy",      {7'b0, busy},      8'h00);
        checkOutput("rst_a_ready",   {7'b0, a_ready},   8'h00);
        checkOutput("rst_b_ready",   {7'b0, b_ready},   8'h00);

        $display("[TB] tie after reset and contention");
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'h20, 1'b1, 8'h30, 1'b1);
        #1;
        checkOutput("idle_busy",    {7'b0, busy},    8'h00);
        checkOutput("idle_a_ready", {7'b0, a_ready}, 8'h00);
        checkOutput("idle_b_ready", {7'b0, b_ready}, 8'h00);
        cycle();
        checkOutput("tie_busy",      {7'b0, busy},      8'h01);
        checkOutput("tie_sel_a",     {7'b0, sel},       8'h01);
        checkOutput("tie_out_valid", {7'b0, out_valid}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'h20 + 8'(i), 1'b1, 8'h30, 1'b1);
            #1;
            checkOutput("cont_a_ready", {7'b0, a_ready}, 8'h01);
            checkOutput("cont_b_ready", {7'b0, b_ready}, 8'h00);
            cycle();
            checkOutput("cont_a_valid", {7'b0, out_valid}, 8'h01);
            checkOutput("cont_a_data",  out_data,          8'h20 + 8'(i));
        end
        #1;
        checkOutput("sw1_a_ready", {7'b0, a_ready}, 8'h00);
        checkOutput("sw1_b_ready", {7'b0, b_ready}, 8'h00);
        checkOutput("sw1_sel",     {7'b0, sel},     8'h01);
        cycle();
        checkOutput("sw1_sel_b",     {7'b0, sel},       8'h00);
        checkOutput("sw1_out_valid", {7'b0, out_valid}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'h24, 1'b1, 8'h30 + 8'(i), 1'b1);
            #1;
            checkOutput("cont_b_ready", {7'b0, b_ready}, 8'h01);
            checkOutput("cont_a_ready", {7'b0, a_ready}, 8'h00);
            cycle();
            checkOutput("cont_b_data", out_data,    8'h30 + 8'(i));
            checkOutput("cont_b_sel",  {7'b0, sel}, 8'h00);
        end
        #1;
        checkOutput("sw2_a_ready", {7'b0, a_ready}, 8'h00);
        checkOutput("sw2_b_ready", {7'b0, b_ready}, 8'h00);
        cycle();
        checkOutput("sw2_sel_a", {7'b0, sel}, 8'h01);

        $display("[TB] idle, second tie");
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        cycle();
        checkOutput("idle2_busy", {7'b0, busy}, 8'h00);
        checkOutput("idle2_sel",  {7'b0, sel},  8'h01);
        applyStimulus(1'b1, 8'h40, 1'b1, 8'hA5, 1'b1);
        #1;
        checkOutput("idle2_a_ready", {7'b0, a_ready}, 8'h00);
        checkOutput("idle2_b_ready", {7'b0, b_ready}, 8'h00);
        cycle();
        checkOutput("tie2_sel_b", {7'b0, sel},  8'h00);
        checkOutput("tie2_busy",  {7'b0, busy}, 8'h01);

        $display("[TB] backpressure in GNT_B");
        applyStimulus(1'b0, 8'h40, 1'b1, 8'hA5, 1'b1);
        #1;
        checkOutput("bp_b_ready0", {7'b0, b_ready}, 8'h01);
        cycle();
        checkOutput("bp_valid", {7'b0, out_valid}, 8'h01);
        checkOutput("bp_data",  out_data,          8'hA5);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 8'h40, 1'b1, 8'hA6, 1'b0);
            #1;
            checkOutput("bp_stall_b_ready", {7'b0, b_ready},   8'h00);
            checkOutput("bp_stall_valid",   {7'b0, out_valid}, 8'h01);
            checkOutput("bp_stall_data",    out_data,          8'hA5);
            cycle();
        end
        checkOutput("bp_hold_data", out_data, 8'hA5);
        applyStimulus(1'b0, 8'h40, 1'b1, 8'hA6, 1'b1);
        #1;
        checkOutput("bp_resume_ready", {7'b0, b_ready}, 8'h01);
        cycle();
        checkOutput("bp_resume_data", out_data, 8'hA6);
        applyStimulus(1'b1, 8'h50, 1'b1, 8'hA7, 1'b1);
        #1;
        checkOutput("bp_cnt2_ready", {7'b0, b_ready}, 8'h01);
        cycle();
        checkOutput("bp_a7_data", out_data, 8'hA7);
        applyStimulus(1'b1, 8'h50, 1'b1, 8'hA8, 1'b1);
        #1;
        checkOutput("bp_cnt3_ready", {7'b0, b_ready}, 8'h01);
        cycle();
        checkOutput("bp_a8_data", out_data, 8'hA8);
        #1;
        checkOutput("bp_sw_b_ready", {7'b0, b_ready}, 8'h00);
        checkOutput("bp_sw_a_ready", {7'b0, a_ready}, 8'h00);
        cycle();
        checkOutput("bp_sw_sel_a",     {7'b0, sel},       8'h01);
        checkOutput("bp_sw_out_valid", {7'b0, out_valid}, 8'h00);

        $display("[TB] early release by A");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 8'h50 + 8'(i), 1'b1, 8'h60, 1'b1);
            #1;
            checkOutput("er_a_ready", {7'b0, a_ready}, 8'h01);
            cycle();
            checkOutput("er_a_data", out_data, 8'h50 + 8'(i));
        end
        applyStimulus(1'b0, 8'h52, 1'b1, 8'h60, 1'b1);
        cycle();
        checkOutput("er_sel_b",     {7'b0, sel},       8'h00);
        checkOutput("er_busy",      {7'b0, busy},      8'h01);
        checkOutput("er_out_valid", {7'b0, out_valid}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'h52, 1'b1, 8'h60 + 8'(i), 1'b1);
            #1;
            checkOutput("er_b_ready", {7'b0, b_ready}, 8'h01);
            cycle();
            checkOutput("er_b_data", out_data, 8'h60 + 8'(i));
        end
        #1;
        checkOutput("er_sw_b_ready", {7'b0, b_ready}, 8'h00);
        cycle();
        checkOutput("er_sw_sel_a", {7'b0, sel}, 8'h01);

        $display("[TB] single requester streaming");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 8'h10 + 8'(i), 1'b0, 8'h00, 1'b1);
            #1;
            checkOutput("single_a_ready", {7'b0, a_ready}, 8'h01);
            checkOutput("single_sel",     {7'b0, sel},     8'h01);
            cycle();
            checkOutput("single_valid", {7'b0, out_valid}, 8'h01);
            checkOutput("single_data",  out_data,          8'h10 + 8'(i));
        end

        $display("[TB] reset mid-stream");
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_out_valid", {7'b0, out_valid}, 8'h00);
        checkOutput("mrst_out_data",  out_data,          8'h00);
        checkOutput("mrst_sel",       {7'b0, sel},       8'h00);
        checkOutput("mrst_busy",      {7'b0, busy},      8'h00);
        checkOutput("mrst_a_ready",   {7'b0, a_ready},   8'h00);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h77, 1'b1);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("rel_busy",    {7'b0, busy},    8'h00);
        checkOutput("rel_b_ready", {7'b0, b_ready}, 8'h00);
        cycle();
        checkOutput("rel_gnt_busy",  {7'b0, busy},      8'h01);
        checkOutput("rel_gnt_sel",   {7'b0, sel},       8'h00);
        checkOutput("rel_gnt_ready", {7'b0, b_ready},   8'h01);
        checkOutput("rel_gnt_valid", {7'b0, out_valid}, 8'h00);
        cycle();
        checkOutput("rel_out_valid", {7'b0, out_valid}, 8'h01);
        checkOutput("rel_out_data",  out_data,          8'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tcon_mux_arbiter.md
Name: tcon_mux_arbiter

Overview:
- Sequencing controller for the 8-lane 2:1 select datapath.
- Arbitrates between two streaming requesters, A (select=1 side) and B (select=0 side), and drives the datapath select line.
- Registers the selected beat into a single output stage with valid/ready backpressure.
- Round-robin arbitration with a bounded burst length, so neither requester starves.

Parameters:
- W, 8, data width per requester and output (one bit per mux lane).
- MAX_BURST, 4, maximum consecutive beats granted to one requester while the other is waiting. Legal range 1..255.
- CNT_W, 8, width of the burst counter. Must satisfy 2^CNT_W > MAX_BURST.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  requester A has a beat
- a_data  in  W  requester A beat
- a_ready  out  1  A beat accepted this cycle
- b_valid  in  1  requester B has a beat
- b_data  in  W  requester B beat
- b_ready  out  1  B beat accepted this cycle
- out_valid  out  1  output register holds a beat
- out_data  out  W  output beat
- out_ready  in  1  downstream accepts out beat
- sel  out  1  datapath select: 1 = A side, 0 = B side
- busy  out  1  state is not IDLE

Behaviour:
- Reset (async, rst_n=0), all registered:
  - state = IDLE, sel = 0, out_valid = 0, out_data = 0, cnt = 0.
  - last_winner = B, so A has first priority after reset.
  - Asserting rst_n low mid-burst drops the held output beat and returns to IDLE immediately. Release is synchronous to the next clk edge.
- load = ~out_valid | out_ready (output stage can take a beat this cycle).
- FSM states: IDLE, GNT_A, GNT_B. busy = (state != IDLE).
- IDLE:
  - a_valid only -> GNT_A.
  - b_valid only -> GNT_B.
  - Both valid -> grant the requester that is not last_winner.
  - Neither valid -> stay IDLE.
  - Entering a grant state: cnt <= 0, sel <= granted side, last_winner <= granted side.
  - No beat is accepted while in IDLE, so arbitration latency is 1 cycle.
- GNT_A: a_ready = load & a_valid-independent & ~(cnt == MAX_BURST & b_valid).
  - a_ready must not depend combinationally on a_valid.
- On an accepted A beat (a_valid & a_ready):
  - out_data <= a_data, out_valid <= 1.
  - cnt <= min(cnt+1, MAX_BURST), saturating.
- GNT_A exit conditions, evaluated every edge:
  - a_valid = 0 -> GNT_B if b_valid, else IDLE.
  - cnt == MAX_BURST & b_valid -> GNT_B. A is not accepted in that cycle.
  - Otherwise stay. Once saturated, A keeps streaming while b_valid = 0.
- GNT_B mirrors GNT_A with A and B swapped.
- Switching grant states: cnt <= 0, sel and last_winner update at the same edge.
- sel is constant throughout a grant and holds its last value in IDLE.
- Output register:
  - If load and no beat accepted -> out_valid <= 0.
  - If ~load -> hold out_valid and out_data, and both readys = 0.
  - cnt does not advance in stall cycles.
- Accept-to-out_valid latency is 1 cycle; throughput is 1 beat/cycle when out_ready = 1.
- Invariants:
  - a_ready & b_ready is never 1.
  - A beat is never duplicated or dropped, except on reset.

Decomposition:
- Shared package tcon_pkg holds:
  - the state enum (IDLE, GNT_A, GNT_B);
  - the side encoding constant (SEL_A = 1, SEL_B = 0), which must match the datapath select polarity;
  - the default W and MAX_BURST.
- One natural sub-module: tcon_out_reg (the W-bit valid/ready output register producing load).
- Arbiter FSM and burst counter stay in the top-level block.

Test Plan:
1. Reset mid-stream:
   - Stimulus: A streaming, out_valid = 1; pull rst_n low between edges.
   - Response: out_valid, sel, busy go 0 immediately. After release with only b_valid = 1: GNT_B next edge, first b_ready one cycle later.
2. Single requester:
   - Stimulus: a_valid = 1 continuously, a_data = 0x10, 0x11, …; b_valid = 0; out_ready = 1.
   - Response: sel = 1; 20 consecutive beats accepted (cnt saturates at 4, no switch); out_data follows 1 cycle behind.
3. Contention, MAX_BURST = 4:
   - Stimulus: both valid from reset, out_ready = 1.
   - Response: A gets 4 beats, then one switch cycle with both readys 0, then B gets 4 beats, then A. Sequence repeats; sel toggles every 5 cycles.
4. Tie after reset:
   - Stimulus: a_valid and b_valid rise in the same cycle.
   - Response: GNT_A first. On the next tie from IDLE, after A was served, GNT_B wins.
5. Backpressure:
   - Stimulus: out_ready = 0 for 3 cycles during GNT_B with out_valid = 1.
   - Response: b_ready = 0; out_data held stable (e.g. 0xA5); cnt frozen. Resumes with no lost or duplicated beat.
6. Early release:
   - Stimulus: A drops a_valid after 2 beats while b_valid = 1.
   - Response: GNT_B at the next edge with cnt = 0; sel = 0.
